// File: rtl/clk_div_pkg.sv
// Shared constants and configuration clamp helpers for the programmable clock divider.
//   DEF_DIV_C : reset period in sys_clk cycles (50 MHz -> 1 kHz)
//   MIN_DIV   : smallest legal period (one cycle high, one cycle low)
//   CALC_W    : working width of the clamp helpers (CNT_W must not exceed it)
package clk_div_pkg;

  localparam int unsigned DEF_DIV_C = 50000;
  localparam int unsigned MIN_DIV   = 2;
  localparam int unsigned CALC_W    = 64;

  // Period clamp: anything below MIN_DIV cannot produce both phases.
  function automatic logic [CALC_W-1:0] clamp_div(input logic [CALC_W-1:0] div);
    return (div < CALC_W'(MIN_DIV)) ? CALC_W'(MIN_DIV) : div;
  endfunction

  // High-phase clamp: at least one cycle high and at least one cycle low.
  function automatic logic [CALC_W-1:0] clamp_high(input logic [CALC_W-1:0] high,
                                                   input logic [CALC_W-1:0] div_c);
    logic [CALC_W-1:0] h;
    h = (high == '0) ? CALC_W'(1) : high;
    return (h > div_c - CALC_W'(1)) ? div_c - CALC_W'(1) : h;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow/active div+high pair, registered outputs.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   en                 : run enable; low holds the counter at 0 and outputs low
//   wr                 : decoded write strobe (ignored while a shadow pair is pending)
//   wr_div, wr_high    : raw requested period / high length, clamped here
//   pending            : shadow pair waiting to be applied
//   clk_out, tick      : registered divided clock and end-of-period strobe
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_DIV  = DEF_DIV_C,
  parameter int unsigned DEF_HIGH = DEF_DIV / 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sh_div_q, sh_div_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic              wrap_c;
  logic              apply_c;
  logic [CALC_W-1:0] cl_div_c;
  logic [CALC_W-1:0] cl_high_c;

  // Next-state: count, swap shadow into active only at the wrap (or at once when idle).
  always_comb begin
    cnt_d     = '0;
    div_d     = div_q;
    high_d    = high_q;
    sh_div_d  = sh_div_q;
    sh_high_d = sh_high_q;
    pending_d = pending_q;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;

    wrap_c    = en && (cnt_q == div_q - CNT_W'(1));
    apply_c   = pending_q && (!en || wrap_c);
    cl_div_c  = clamp_div(CALC_W'(wr_div));
    cl_high_c = clamp_high(CALC_W'(wr_high), cl_div_c);

    if (en && !wrap_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Apply and accept are exclusive: apply needs pending, accept needs !pending.
    if (apply_c) begin
      div_d     = sh_div_q;
      high_d    = sh_high_q;
      pending_d = 1'b0;
    end else if (wr && !pending_q) begin
      sh_div_d  = CNT_W'(cl_div_c);
      sh_high_d = CNT_W'(cl_high_c);
      pending_d = 1'b1;
    end

    clk_out_d = en && (cnt_q < high_q);
    tick_d    = wrap_c;
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q     <= '0;
      div_q     <= CNT_W'(DEF_DIV);
      high_q    <= CNT_W'(DEF_HIGH);
      sh_div_q  <= CNT_W'(DEF_DIV);
      sh_high_q <= CNT_W'(DEF_HIGH);
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      sh_div_q  <= sh_div_d;
      sh_high_q <= sh_high_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending = pending_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider with glitch-free period reprogramming.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   en[CH]             : per-channel run enable
//   cfg_wr/cfg_ch      : configuration write request and target channel
//   cfg_div/cfg_high   : requested period and high-phase length (clamped per channel)
//   cfg_ready          : combinational; target channel can accept a write now
//   clk_out[CH]        : registered divided clocks
//   tick[CH]           : registered one-cycle end-of-period strobes
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CH       = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_DIV  = DEF_DIV_C,
  parameter int unsigned DEF_HIGH = DEF_DIV / 2
) (
  input  logic                                 sys_clk,
  input  logic                                 sys_rst_n,
  input  logic [CH-1:0]                        en,
  input  logic                                 cfg_wr,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                     cfg_div,
  input  logic [CNT_W-1:0]                     cfg_high,
  output logic                                 cfg_ready,
  output logic [CH-1:0]                        clk_out,
  output logic [CH-1:0]                        tick
);

  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned SEL_N = 1 << CH_W;

  logic [CH-1:0]    pending;
  logic [SEL_N-1:0] pending_ext;
  logic             ch_valid_c;
  logic [CH-1:0]    wr_sel;

  // Channel decode; indices past CH read as not-ready so writes to them drop.
  always_comb begin
    pending_ext = SEL_N'(pending);
    ch_valid_c  = 32'(cfg_ch) < CH;
    cfg_ready   = ch_valid_c && !pending_ext[cfg_ch];
    wr_sel      = '0;
    for (int i = 0; i < CH; i++) begin
      wr_sel[i] = cfg_wr && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_chan (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .en       (en[g]),
      .wr       (wr_sel[g]),
      .wr_div   (cfg_div),
      .wr_high  (cfg_high),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog. DEF_DIV is shortened to 200 so several
// default periods fit a short run; DEF_HIGH keeps its DEF_DIV/2 default.
module tb_clk_div_prog;

  localparam int unsigned CH    = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned DIV   = 200;
  localparam int unsigned HIGH  = DIV / 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [CH-1:0]    en;
  logic             cfg_wr;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_ready;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;

  typedef struct packed {
    logic [CH-1:0] clk;
    logic [CH-1:0] tck;
    logic          rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  clk_div_prog #(
    .CH     (CH),
    .CNT_W  (CNT_W),
    .DEF_DIV(DIV)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_high (cfg_high),
    .cfg_ready(cfg_ready),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected {clk_out, tick} after the k-th enabled edge (k >= 1) of a period div/high.
  function automatic logic [1:0] ph(input int k, input int div, input int high);
    int m;
    m = (k - 1) % div;
    return {(m < high), (m == div - 1)};
  endfunction

  function automatic exp_t mk(input logic [CH-1:0] c, input logic [CH-1:0] t, input logic r);
    exp_t e;
    e.clk = c;
    e.tck = t;
    e.rdy = r;
    return e;
  endfunction

  task automatic do_reset();
    cfg_wr    = 1'b0;
    en        = '0;
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    sys_rst_n = 1'b1;
    en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    #1 sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    n_checks++;
    if (clk_out !== '0 || tick !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: clk_out=%b tick=%b, expected 0000 0000", clk_out, tick);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < CH; i++) begin
      cfg_ch = 2'(i);
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_ready ch%0d: cfg_ready=%b, expected 1", i, cfg_ready);
      end
    end
    cfg_ch = '0;
    for (int k = 1; k <= 3; k++) begin
      sb_q.push_back(mk('0, '0, 1'b1));
      @(posedge sys_clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                 k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
      end
    end
  endtask

  task automatic test_default_period();
    exp_t       e;
    logic [1:0] p;
    int         ticks, highs;
    do_reset();
    cfg_ch = 2'd0;
    en = 4'b0001;
    ticks = 0;
    highs = 0;
    for (int k = 1; k <= 2 * DIV + 2; k++) begin
      p = ph(k, DIV, HIGH);
      sb_q.push_back(mk(CH'(p[1]), CH'(p[0]), 1'b1));
      @(posedge sys_clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL default_period k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                 k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
      end
      ticks += int'(tick[0]);
      highs += int'(clk_out[0]);
    end
    n_checks++;
    if (ticks != 2) begin
      n_fail++;
      $display("FAIL default_tick_count: got %0d, expected 2", ticks);
    end
    n_checks++;
    if (highs != 2 * HIGH + 2) begin
      n_fail++;
      $display("FAIL default_high_count: got %0d, expected %0d", highs, 2 * HIGH + 2);
    end
  endtask

  // Write 5/2 at cnt=100, then a refused 7/3 while pending; new period starts at the wrap.
  task automatic test_write_at_wrap();
    exp_t       e;
    logic [1:0] p;
    do_reset();
    cfg_ch = 2'd0;
    en = 4'b0001;
    for (int k = 1; k <= DIV + 16; k++) begin
      cfg_wr   = (k == 101) || (k == 151);
      cfg_div  = (k == 101) ? 32'd5 : 32'd7;
      cfg_high = (k == 101) ? 32'd2 : 32'd3;
      p = (k <= DIV) ? ph(k, DIV, HIGH) : ph(k - DIV, 5, 2);
      sb_q.push_back(mk(CH'(p[1]), CH'(p[0]), (k < 101) || (k >= DIV)));
      @(posedge sys_clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL write_at_wrap k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                 k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
      end
    end
    cfg_wr = 1'b0;
  endtask

  // div=1/high=0 -> 2/1; div=4/high=9 -> 4/3; both written while disabled.
  task automatic test_clamp();
    exp_t       e;
    logic [1:0] p;
    int         dv, hv;
    do_reset();
    cfg_ch = 2'd3;
    for (int pass = 0; pass < 2; pass++) begin
      dv = (pass == 0) ? 2 : 4;
      hv = (pass == 0) ? 1 : 3;
      for (int k = -1; k <= 8; k++) begin
        en       = (k >= 1) ? 4'b1000 : 4'b0000;
        cfg_wr   = (k == -1);
        cfg_div  = (pass == 0) ? 32'd1 : 32'd4;
        cfg_high = (pass == 0) ? 32'd0 : 32'd9;
        p = (k >= 1) ? ph(k, dv, hv) : 2'b00;
        sb_q.push_back(mk(CH'(p[1]) << 3, CH'(p[0]) << 3, k != -1));
        @(posedge sys_clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
          n_fail++;
          $display("FAIL clamp pass%0d k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                   pass, k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
        end
      end
    end
    cfg_wr = 1'b0;
  endtask

  // ch1 dropped in its high phase, reprogrammed while idle, restarted; ch0 runs undisturbed.
  task automatic test_en_drop();
    exp_t       e;
    logic [1:0] p0, p1;
    do_reset();
    cfg_ch = 2'd1;
    for (int k = 1; k <= 53 + 14; k++) begin
      en       = (k >= 51 && k <= 53) ? 4'b0001 : 4'b0011;
      cfg_wr   = (k == 52);
      cfg_div  = 32'd6;
      cfg_high = 32'd2;
      p0 = ph(k, DIV, HIGH);
      p1 = (k <= 50) ? ph(k, DIV, HIGH) : (k <= 53) ? 2'b00 : ph(k - 53, 6, 2);
      sb_q.push_back(mk({2'b00, p1[1], p0[1]}, {2'b00, p1[0], p0[0]}, k != 52));
      @(posedge sys_clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL en_drop k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                 k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
      end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset_pending();
    exp_t       e;
    logic [1:0] p;
    do_reset();
    cfg_ch = 2'd2;
    en = 4'b0100;
    for (int k = 1; k <= 30; k++) begin
      cfg_wr   = (k == 21);
      cfg_div  = 32'd3;
      cfg_high = 32'd1;
      p = ph(k, DIV, HIGH);
      sb_q.push_back(mk(CH'(p[1]) << 2, CH'(p[0]) << 2, k < 21));
      @(posedge sys_clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL pend_before_rst k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                 k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
      end
    end
    cfg_wr = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    n_checks++;
    if (clk_out !== '0 || tick !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: clk_out=%b tick=%b, expected 0000 0000", clk_out, tick);
    end
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_ready: cfg_ready=%b, expected 1", cfg_ready);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int k = 1; k <= DIV + 5; k++) begin
      p = ph(k, DIV, HIGH);
      sb_q.push_back(mk(CH'(p[1]) << 2, CH'(p[0]) << 2, 1'b1));
      @(posedge sys_clk);
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (clk_out !== e.clk || tick !== e.tck || cfg_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL pend_after_rst k=%0d: clk_out=%b tick=%b ready=%b, expected %b %b %b",
                 k, clk_out, tick, cfg_ready, e.clk, e.tck, e.rdy);
      end
    end
    for (int i = 0; i < CH; i++) begin
      cfg_ch = 2'(i);
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL post_rst_ready ch%0d: cfg_ready=%b, expected 1", i, cfg_ready);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_default_period();
    test_write_at_wrap();
    test_clamp();
    test_en_drop();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
